// File: rtl/ntt_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_arith_pkg
//  Description : Shared constants and helpers for the NTT arithmetic datapath
//                (op encodings, default modulus/width, clog2 helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package ntt_arith_pkg;

    // Op encoding: bit 1 selects the halved variant, bit 0 selects subtract.
    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] OP_ADD_HALF = 2'b10;
    localparam logic [1:0] OP_SUB_HALF = 2'b11;

    // Kyber-style default modulus and the lane width that holds it.
    localparam int DEFAULT_MODULUS    = 3329;
    localparam int DEFAULT_DATA_WIDTH = 14;

    // Number of bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : ntt_arith_pkg
`default_nettype wire

// File: rtl/mod_lane_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : mod_lane_addsub
//  Description : One lane of the modular add/subtract pipeline. S1 computes
//                (x +/- y) mod q, S2 optionally multiplies by 2^-1 mod q.
//                Pure datapath; stage enables come from the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_lane_addsub
    import ntt_arith_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MODULUS    = DEFAULT_MODULUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load_s1,
    input  logic                  i_load_s2,
    input  logic [1:0]            i_op,
    input  logic [1:0]            i_op_s1,
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_y,
    output logic [DATA_WIDTH-1:0] o_z
);

    localparam logic [DATA_WIDTH:0] c_mod = (DATA_WIDTH+1)'(MODULUS);

    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;
    logic [DATA_WIDTH:0]   w_red;
    logic                  w_is_sub;
    logic [DATA_WIDTH:0]   w_half_sum;
    logic [DATA_WIDTH-1:0] w_z_next;
    logic                  w_unused_bits;
    logic [DATA_WIDTH-1:0] r_red;
    logic [DATA_WIDTH-1:0] r_z;

    // S1 combinational reduce: single conditional correction at DATA_WIDTH+1 bits
    always_comb begin
        w_is_sub = (i_op == OP_SUB) || (i_op == OP_SUB_HALF);
        w_sum    = {1'b0, i_x} + {1'b0, i_y};
        w_diff   = {1'b0, i_x} - {1'b0, i_y};
        w_red    = '0;
        if (w_is_sub) begin
            // Bit DATA_WIDTH of the difference is the borrow out.
            w_red = w_diff[DATA_WIDTH] ? (w_diff + c_mod) : w_diff;
        end else begin
            w_red = (w_sum >= c_mod) ? (w_sum - c_mod) : w_sum;
        end
    end

    // S2 combinational halve: odd r becomes even after adding the odd modulus
    always_comb begin
        w_half_sum = {1'b0, r_red} + c_mod;
        w_z_next   = r_red;
        if ((i_op_s1 == OP_ADD_HALF) || (i_op_s1 == OP_SUB_HALF)) begin
            w_z_next = r_red[0] ? w_half_sum[DATA_WIDTH:1]
                                : {1'b0, r_red[DATA_WIDTH-1:1]};
        end
    end

    // Top bit of the reduced value and the always-zero LSB of the halving sum
    // carry no information for in-range operands.
    assign w_unused_bits = w_red[DATA_WIDTH] ^ w_half_sum[0];

    // Stage registers; each stage loads only when it takes a real transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_red <= '0;
            r_z   <= '0;
        end else begin
            if (i_load_s1) r_red <= w_red[DATA_WIDTH-1:0];
            if (i_load_s2) r_z   <= w_z_next;
        end
    end

    assign o_z = r_z;

endmodule : mod_lane_addsub
`default_nettype wire

// File: rtl/modular_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : modular_addsub_pipe
//  Description : Two-stage, multi-lane modular add/subtract unit with
//                valid/ready handshake, tag pass-through and a sticky
//                operand range-error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module modular_addsub_pipe
    import ntt_arith_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MODULUS    = DEFAULT_MODULUS,
    parameter int LANES      = 2,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_op,
    input  logic [LANES*DATA_WIDTH-1:0] in_x,
    input  logic [LANES*DATA_WIDTH-1:0] in_y,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_z,
    output logic [TAG_WIDTH-1:0]        out_tag,
    output logic                        range_err
);

    localparam logic [DATA_WIDTH-1:0] c_mod = DATA_WIDTH'(MODULUS);

    // Elaboration-time guard on the parameter set.
    generate
        if ((DATA_WIDTH < clog2(MODULUS)) || (TAG_WIDTH < 1) || (LANES < 1)) begin : g_param_check
            $error("modular_addsub_pipe: illegal parameter combination");
        end
    endgenerate

    logic                 w_adv;
    logic                 w_accept;
    logic [LANES-1:0]     w_oor;
    logic                 r_v1;
    logic                 r_v2;
    logic [1:0]           r_op1;
    logic [TAG_WIDTH-1:0] r_tag1;
    logic [TAG_WIDTH-1:0] r_tag2;
    logic                 r_err;

    // The whole pipe moves together; a full output stage blocks everything.
    assign w_adv    = ~r_v2 | out_ready;
    assign w_accept = in_valid & w_adv;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_oor[i] = (in_x[i*DATA_WIDTH +: DATA_WIDTH] >= c_mod) ||
                              (in_y[i*DATA_WIDTH +: DATA_WIDTH] >= c_mod);

            mod_lane_addsub #(
                .DATA_WIDTH (DATA_WIDTH),
                .MODULUS    (MODULUS)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_load_s1 (w_accept),
                .i_load_s2 (w_adv & r_v1),
                .i_op      (in_op),
                .i_op_s1   (r_op1),
                .i_x       (in_x[i*DATA_WIDTH +: DATA_WIDTH]),
                .i_y       (in_y[i*DATA_WIDTH +: DATA_WIDTH]),
                .o_z       (out_z[i*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Stage valid bits, op/tag shadow registers and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_op1  <= OP_ADD;
            r_tag1 <= '0;
            r_tag2 <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_adv) begin
                // Bubbles propagate as bubbles; nothing collapses.
                r_v1 <= w_accept;
                r_v2 <= r_v1;
                if (w_accept) begin
                    r_op1  <= in_op;
                    r_tag1 <= in_tag;
                end
                if (r_v1) r_tag2 <= r_tag1;
            end
            if (w_accept && (|w_oor)) r_err <= 1'b1;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v2;
    assign out_tag   = r_tag2;
    assign range_err = r_err;

endmodule : modular_addsub_pipe
`default_nettype wire

// File: tb/tb_modular_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modular_addsub_pipe
//  Description : Self-checking bench for modular_addsub_pipe: directed
//                vector table plus backpressure, range-error and reset
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modular_addsub_pipe;
    import ntt_arith_pkg::*;

    localparam int DW = 14;
    localparam int TW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [2*DW-1:0] in_x;
    logic [2*DW-1:0] in_y;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [2*DW-1:0] out_z;
    logic [TW-1:0] out_tag;
    logic          range_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        int x0, y0, x1, y1;
        int tag;
        int z0, z1;
    } vec_t;

    vec_t vecs[8];

    modular_addsub_pipe #(
        .DATA_WIDTH (DW),
        .MODULUS    (3329),
        .LANES      (2),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .range_err (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input int x0, input int y0,
                         input int x1, input int y1, input int tag);
        in_op  = op;
        in_x   = {DW'(x1), DW'(x0)};
        in_y   = {DW'(y1), DW'(y0)};
        in_tag = TW'(tag);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        drive(v.op, v.x0, v.y0, v.x1, v.y1, v.tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({s, "_valid_s1"}, int'(out_valid), 0);
        tick();
        check({s, "_valid"}, int'(out_valid), 1);
        check({s, "_z0"}, int'(out_z[0 +: DW]), v.z0);
        check({s, "_z1"}, int'(out_z[DW +: DW]), v.z1);
        check({s, "_tag"}, int'(out_tag), v.tag);
        tick();
        check({s, "_valid_drop"}, int'(out_valid), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // op, x0, y0, x1, y1, tag, z0, z1
        vecs[0] = '{OP_ADD,      3000,  500, 3328, 3328, 8'h5A,  171, 3327};
        vecs[1] = '{OP_SUB,         5,   10,   10,   10, 8'h11, 3324,    0};
        vecs[2] = '{OP_ADD_HALF,    1,    2,    2,    2, 8'h22, 1666,    2};
        vecs[3] = '{OP_SUB_HALF,    0,    1, 3328,    0, 8'h33, 1664, 1664};
        vecs[4] = '{OP_ADD,         0,    0, 3328,    1, 8'h44,    0,    0};
        vecs[5] = '{OP_SUB,         0, 3328, 3328,    0, 8'h55,    1, 3328};
        vecs[6] = '{OP_ADD_HALF, 3328, 3328,    0,    1, 8'h66, 3328, 1665};
        vecs[7] = '{OP_SUB_HALF,    1,    0,    2,    5, 8'h77, 1665, 1663};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(OP_ADD, 0, 0, 0, 0, 0);

        // Reset then idle
        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_range_err", int'(range_err), 0);
        check("rst_in_ready",  int'(in_ready), 1);
        check("rst_out_z",     int'(out_z), 0);
        check("rst_out_tag",   int'(out_tag), 0);

        // Directed vector table
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        check("no_err_after_vecs", int'(range_err), 0);

        // Backpressure stream: 6 ADDs, out_ready low for cycles 3..5
        begin
            int sent = 0;
            int recv = 0;
            int cyc  = 0;
            bit stall_prev = 0;
            logic [2*DW-1:0] held_z;
            logic [TW-1:0]   held_tag;
            held_z   = '0;
            held_tag = '0;
            while (recv < 6 && cyc < 40) begin
                if (stall_prev) begin
                    check("stall_valid", int'(out_valid), 1);
                    check("stall_z",     int'(out_z), int'(held_z));
                    check("stall_tag",   int'(out_tag), int'(held_tag));
                end
                out_ready = !(cyc >= 3 && cyc <= 5);
                if (sent < 6) begin
                    drive(OP_ADD, (sent + 1) * 100, sent + 1, 3328, sent + 1, sent + 1);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                check("bp_in_ready", int'(in_ready), int'(!out_valid || out_ready));
                if (out_valid && out_ready) begin
                    check("bp_tag", int'(out_tag), recv + 1);
                    check("bp_z0",  int'(out_z[0 +: DW]), (recv + 1) * 101);
                    check("bp_z1",  int'(out_z[DW +: DW]), recv);
                    recv++;
                end
                stall_prev = out_valid && !out_ready;
                held_z     = out_z;
                held_tag   = out_tag;
                if (in_valid && in_ready) sent++;
                tick();
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("bp_recv_count", recv, 6);
            tick();
            tick();
            check("bp_no_dup", int'(out_valid), 0);
        end

        // Range error on lane0 x, sticky
        drive(OP_ADD, 3329, 0, 0, 0, 8'h99);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("err_set", int'(range_err), 1);
        tick();
        tick();
        tick();
        check("err_sticky", int'(range_err), 1);

        // Valid transaction then reset while it is in flight
        drive(OP_ADD, 1, 1, 1, 1, 8'hAB);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_err",   int'(range_err), 0);
        check("midrst_tag",   int'(out_tag), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (out_valid) seen++;
            end
            check("midrst_flushed", seen, 0);
        end

        // Range error on lane1 y
        drive(OP_SUB, 0, 0, 0, 4000, 8'h01);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("err_lane1_y", int'(range_err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_modular_addsub_pipe
`default_nettype wire
